// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file's single write port.
// Define RF_WB_FWD_EN to forward the in-flight commit onto the read paths.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wb_busy
);

    logic last_grant;
    logic gnt0;
    logic gnt1;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        gnt0 = reset_n && wb0_valid && (!wb1_valid || last_grant);
        gnt1 = reset_n && wb1_valid && (!wb0_valid || !last_grant);
    end

    assign wb0_ready = gnt0;
    assign wb1_ready = gnt1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant  <= 1'b1;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else begin
            unique case (1'b1)
                gnt0: begin
                    last_grant  <= 1'b0;
                    rg_wrt_en   <= (wb0_addr != '0);
                    rg_wrt_addr <= wb0_addr;
                    rg_wrt_data <= wb0_data;
                end
                gnt1: begin
                    last_grant  <= 1'b1;
                    rg_wrt_en   <= (wb1_addr != '0);
                    rg_wrt_addr <= wb1_addr;
                    rg_wrt_data <= wb1_data;
                end
                default: rg_wrt_en <= 1'b0;
            endcase
        end
    end

    assign wb_busy = rg_wrt_en;

`ifdef RF_WB_FWD_EN
    assign rd_data1 = (rg_wrt_en && rd_addr1 == rg_wrt_addr) ? rg_wrt_data : rf_rd_data1;
    assign rd_data2 = (rg_wrt_en && rd_addr2 == rg_wrt_addr) ? rg_wrt_data : rf_rd_data2;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign rd_data1 = rf_rd_data1;
    assign rd_data2 = rf_rd_data2;
`endif

endmodule
